// File: rtl/pdm_capture.sv
// pdm_capture: PDM mic clock generator, edge-selectable bit capture, tagged bit FIFO and packetised 1-bit stream with CSRs
module pdm_capture #(
    parameter int CLK_DIV_DEFAULT    = 24,
    parameter int PACKET_LEN_DEFAULT = 1024,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    output logic        oPDM_CLK,
    input  logic        iPDM_DATA,
    output logic        s_clock,
    output logic        s_data_valid,
    input  logic        s_ready,
    output logic        s_start_packet,
    output logic        s_end_packet,
    output logic        s_data,
    input  logic [2:0]  iCSR_ADDRESS,
    input  logic        iCSR_READ,
    output logic [31:0] oCSR_READ_DATA,
    input  logic        iCSR_WRITE,
    input  logic [31:0] iCSR_WRITE_DATA
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN_STOP} state_t;
    state_t state, state_nx;

    logic        enable, edge_sel, overflow, pdm_clk, sync1, sync2;
    logic [15:0] divider, packet_len, pkt_len_cur, div_cnt, pkt_cnt, pkt_cnt_nx;
    logic [15:0] div_eff, len_eff, len_act;
    logic [31:0] sample_count, rdata, rd_mux, status;
    logic [2:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] level;
    logic running, tc, sample_evt, full, empty, wr, rd, is_start, is_end, pdm_clear, csr_wr_status;
    logic unused_wdata;

    assign unused_wdata  = ^iCSR_WRITE_DATA[31:16];
    assign div_eff       = divider == 16'd0 ? 16'd1 : divider;
    assign len_eff       = packet_len == 16'd0 ? 16'd1 : packet_len;
    assign running       = state != IDLE;
    assign tc            = running && div_cnt >= div_eff - 16'd1;
    // old level equals EDGE exactly when the toggle is the selected edge
    assign sample_evt    = tc && (edge_sel == pdm_clk);
    assign full          = level == (AW+1)'(FIFO_DEPTH);
    assign empty         = level == '0;
    assign wr            = sample_evt && !full;
    assign rd            = !empty && s_ready;
    assign is_start      = pkt_cnt == 16'd0;
    // a new PACKET_LEN is latched only when a packet starts
    assign len_act       = is_start ? len_eff : pkt_len_cur;
    assign is_end        = pkt_cnt == len_act - 16'd1;
    assign pkt_cnt_nx    = !wr ? pkt_cnt : is_end ? 16'd0 : pkt_cnt + 16'd1;
    assign pdm_clear     = state == IDLE || state_nx == IDLE;
    assign csr_wr_status = iCSR_WRITE && iCSR_ADDRESS == 3'd3 && iCSR_WRITE_DATA[0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = enable ? RUN : IDLE;
            RUN:        state_nx = enable ? RUN : pkt_cnt_nx != 16'd0 ? DRAIN_STOP : IDLE;
            DRAIN_STOP: state_nx = enable ? RUN : (wr && is_end) ? IDLE : DRAIN_STOP;
            default:    state_nx = IDLE;
        endcase
    end

    assign status = {16'd0, 8'(level), 5'd0, running, empty, overflow};

    always_comb begin
        rd_mux = iCSR_ADDRESS == 3'd0 ? {30'd0, edge_sel, enable} :
                 iCSR_ADDRESS == 3'd1 ? {16'd0, divider} :
                 iCSR_ADDRESS == 3'd2 ? {16'd0, packet_len} :
                 iCSR_ADDRESS == 3'd3 ? status :
                 iCSR_ADDRESS == 3'd4 ? sample_count : 32'd0;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state        <= IDLE;
            enable       <= 1'b0;
            edge_sel     <= 1'b0;
            divider      <= 16'(CLK_DIV_DEFAULT);
            packet_len   <= 16'(PACKET_LEN_DEFAULT);
            pkt_len_cur  <= 16'(PACKET_LEN_DEFAULT);
            overflow     <= 1'b0;
            pdm_clk      <= 1'b0;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            div_cnt      <= '0;
            pkt_cnt      <= '0;
            sample_count <= '0;
            wp           <= '0;
            rp           <= '0;
            level        <= '0;
            rdata        <= '0;
        end else begin
            state        <= state_nx;
            sync1        <= iPDM_DATA;
            sync2        <= sync1;
            div_cnt      <= (pdm_clear || tc) ? 16'd0 : div_cnt + 16'd1;
            pdm_clk      <= pdm_clear ? 1'b0 : pdm_clk ^ tc;
            pkt_cnt      <= pdm_clear ? 16'd0 : pkt_cnt_nx;
            pkt_len_cur  <= (wr && is_start) ? len_eff : pkt_len_cur;
            sample_count <= sample_count + 32'(wr);
            wp           <= wp + AW'(wr);
            rp           <= rp + AW'(rd);
            level        <= level + (AW+1)'(wr) - (AW+1)'(rd);
            overflow     <= (sample_evt && full) ? 1'b1 : csr_wr_status ? 1'b0 : overflow;
            rdata        <= iCSR_READ ? rd_mux : rdata;
            if (iCSR_WRITE && iCSR_ADDRESS == 3'd0)
                {edge_sel, enable} <= iCSR_WRITE_DATA[1:0];
            if (iCSR_WRITE && iCSR_ADDRESS == 3'd1)
                divider <= iCSR_WRITE_DATA[15:0];
            if (iCSR_WRITE && iCSR_ADDRESS == 3'd2)
                packet_len <= iCSR_WRITE_DATA[15:0];
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (wr)
            mem[wp] <= {is_start, is_end, sync2};
    end

    assign oPDM_CLK       = pdm_clk;
    assign s_clock        = iCLOCK;
    assign s_data_valid   = !empty;
    assign {s_start_packet, s_end_packet, s_data} = empty ? 3'b000 : mem[rp];
    assign oCSR_READ_DATA = rdata;
endmodule

// File: doc/pdm_capture.md
Name: pdm_capture

Overview:
- Upstream neighbour of the audio filter.
- Generates the PDM microphone clock and samples the 1-bit mic data on a selectable edge.
- Buffers the bits in a small FIFO and presents them as a packetised 1-bit stream (valid/ready, start/end packet) that connects directly to the filter's d_ sink.
- Configured and monitored through a 3-bit-address CSR port.

Parameters:
- CLK_DIV_DEFAULT, 24: reset value of the DIVIDER CSR (PDM clock half-period, in iCLOCK cycles).
- PACKET_LEN_DEFAULT, 1024: reset value of the PACKET_LEN CSR (bits per packet).
- FIFO_DEPTH, 16: bit FIFO depth; power of 2, minimum 4.

Ports:
- iCLOCK  in  1  single clock for all logic.
- iRESET  in  1  synchronous, active-high reset.
- oPDM_CLK  out  1  clock to the microphone.
- iPDM_DATA  in  1  microphone data; asynchronous, so it passes through a 2-flop synchroniser.
- s_clock  out  1  driven by iCLOCK.
- s_data_valid  out  1  stream valid.
- s_ready  in  1  stream ready from downstream.
- s_start_packet  out  1  first bit of a packet.
- s_end_packet  out  1  last bit of a packet.
- s_data  out  1  PDM bit.
- iCSR_ADDRESS  in  3  register select.
- iCSR_READ  in  1  read strobe.
- oCSR_READ_DATA  out  32  registered read data.
- iCSR_WRITE  in  1  write strobe.
- iCSR_WRITE_DATA  in  32  write data.

Behaviour:
- Clocking: one clock (iCLOCK); synchronous active-high reset (iRESET). iCLOCK and iRESET name the clock and reset ports, as decided.
- Reset values:
  - oPDM_CLK=0, s_data_valid=0, s_start_packet=0, s_end_packet=0, s_data=0, oCSR_READ_DATA=0.
  - FIFO emptied; all counters 0.
  - CONTROL=0, DIVIDER=CLK_DIV_DEFAULT, PACKET_LEN=PACKET_LEN_DEFAULT.
  - A reset mid-packet discards all buffered bits; no end_packet is emitted for the truncated packet.
- CSR map (write takes effect the next cycle; read data appears the cycle after iCSR_READ; unmapped addresses read 0 and ignore writes):
  - 0 CONTROL: bit0 ENABLE; bit1 EDGE (0 = sample on oPDM_CLK rising event, 1 = falling event).
  - 1 DIVIDER [15:0]: a value of 0 is treated as 1.
  - 2 PACKET_LEN [15:0]: a value of 0 is treated as 1. A write applies from the next packet start.
  - 3 STATUS (read):
    - bit0 OVERFLOW (sticky; writing 1 to bit0 clears it);
    - bit1 FIFO_EMPTY;
    - bit2 RUNNING;
    - [15:8] FIFO level.
  - 4 SAMPLE_COUNT [31:0]: bits written into the FIFO; wraps at 2^32; cleared by reset only.
- Divider:
  - While RUNNING, a 16-bit counter runs 0..DIVIDER-1.
  - At terminal count, oPDM_CLK toggles and the counter restarts.
  - The toggle cycle is an "edge event", rising or falling according to the new level.
  - With DIVIDER=1, oPDM_CLK toggles every cycle.
- Sampling: on an edge event matching EDGE, the synchronised iPDM_DATA (2-flop) is written to the FIFO.
- Framing:
  - A packet bit counter increments on each FIFO write.
  - The bit at count 0 is tagged start; the bit at count PACKET_LEN-1 is tagged end, and the counter then returns to 0.
  - With PACKET_LEN=1, every bit carries both start and end.
  - Tags are stored in the FIFO alongside the data (3 bits per entry).
- Run control (RUNNING flag): states IDLE, RUN, DRAIN_STOP.
  - IDLE → RUN when ENABLE=1. The divider and packet counter are cleared on entry, and oPDM_CLK starts low.
  - RUN → DRAIN_STOP when ENABLE=0 and the packet counter is not 0.
  - RUN → IDLE when ENABLE=0 and the packet counter is 0.
  - DRAIN_STOP keeps capturing until the end-tagged bit is written, then goes to IDLE.
  - ENABLE=1 during DRAIN_STOP returns to RUN.
  - In IDLE, oPDM_CLK is held at 0.
- Overflow:
  - A sample event while the FIFO is full drops the bit and sets OVERFLOW.
  - Dropped bits do not advance the packet counter or SAMPLE_COUNT, so packet lengths stay exact.
  - A write and a read in the same cycle with the FIFO full is a full-FIFO write: the write is dropped.
- Stream output:
  - First-word fall-through: s_data_valid = FIFO not empty, and the s_data/tag outputs show the head entry.
  - A transfer occurs when s_data_valid and s_ready are both high.
  - The outputs hold stable while valid is high and ready is low.
  - A write into an empty FIFO appears on the outputs the next cycle (1-cycle latency).
  - Simultaneous read and write keeps the level unchanged.
  - The FIFO keeps draining in IDLE.

Test Plan:
- Reset, then ENABLE=1, DIVIDER=2, EDGE=0, s_ready=1, iPDM_DATA constant 1 → oPDM_CLK period is 4 cycles; one bit per 4 cycles; s_data=1.
- PACKET_LEN=4, alternating mic data, 12 bits captured → s_start_packet on bits 0, 4, 8; s_end_packet on bits 3, 7, 11; data pattern preserved; SAMPLE_COUNT=12.
- s_ready=0 for 100 µs with DIVIDER=1 → FIFO fills to 16, OVERFLOW=1, level reads 16. Release ready → 16 bits are output and the framing still totals PACKET_LEN per packet. Writing 1 to STATUS bit0 clears OVERFLOW.
- ENABLE cleared after bit 2 of a PACKET_LEN=8 packet → capture continues through bit 7 (end tag), then RUNNING=0 and oPDM_CLK is held at 0.
- iRESET asserted mid-packet with the FIFO holding 5 bits → next cycle s_data_valid=0, all CSRs at reset values, no end_packet output.
- DIVIDER=0 and PACKET_LEN=0 written → they behave as 1: oPDM_CLK toggles every cycle and every bit carries both start and end; address 7 reads 0.
